// File: rtl/taxi_dma_ram_mux_pkg.sv
// Shared helpers for the DMA RAM read multiplexer.
package taxi_dma_ram_mux_pkg;

  // Width of the port index prepended to the RAM select field.
  function automatic int unsigned calc_idx_w(input int unsigned ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

  // Select width seen by the RAM: {port index, client select}.
  function automatic int unsigned calc_m_sel_w(input int unsigned s_sel_w,
                                               input int unsigned ports);
    return s_sel_w + calc_idx_w(ports);
  endfunction

  // Pointer width for the port-index FIFO.
  function automatic int unsigned calc_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/taxi_dma_ram_mux_rd_seg.sv
// One RAM segment: round-robin arbiter, registered command stage and an
// in-order FIFO of granted port indices used to route read responses.
module taxi_dma_ram_mux_rd_seg
  import taxi_dma_ram_mux_pkg::*;
#(
  parameter int unsigned PORTS      = 2,
  parameter int unsigned S_SEL_W    = 1,
  parameter int unsigned SEG_ADDR_W = 12,
  parameter int unsigned FIFO_DEPTH = 16,
  localparam int unsigned IDX_W     = calc_idx_w(PORTS),
  localparam int unsigned M_SEL_W   = calc_m_sel_w(S_SEL_W, PORTS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PORTS*S_SEL_W-1:0]      s_cmd_sel,
  input  logic [PORTS*SEG_ADDR_W-1:0]   s_cmd_addr,
  input  logic [PORTS-1:0]              s_cmd_valid,
  output logic [PORTS-1:0]              s_cmd_ready,
  output logic [PORTS-1:0]              s_resp_valid,
  input  logic [PORTS-1:0]              s_resp_ready,
  output logic [M_SEL_W-1:0]            m_cmd_sel,
  output logic [SEG_ADDR_W-1:0]         m_cmd_addr,
  output logic                          m_cmd_valid,
  input  logic                          m_cmd_ready,
  input  logic                          m_resp_valid,
  output logic                          m_resp_ready
);

  localparam int unsigned PTR_W = calc_ptr_w(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [IDX_W-1:0]      idx;
    logic [S_SEL_W-1:0]    sel;
    logic [SEG_ADDR_W-1:0] addr;
  } cmd_t;

  cmd_t             oreg_q, oreg_d, win_cmd;
  logic             m_cmd_valid_q, m_cmd_valid_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] fifo_mem_q [FIFO_DEPTH];

  logic             can_load, fifo_full, fifo_empty, grant, req_found;
  logic             found_hi, found_lo, push, pop, head_ready;
  logic [IDX_W-1:0] win_hi, win_lo, winner, head;

  assign can_load   = !m_cmd_valid_q || m_cmd_ready;
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_mem_q[rd_ptr_q];
  assign grant      = rst_n && can_load && !fifo_full && req_found;
  assign push       = grant;
  assign pop        = m_resp_valid && m_resp_ready;

  // Round-robin winner: scan ports >= rr pointer first, then wrap from 0.
  // Two flat passes replace a modular index so the port select stays constant.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (s_cmd_valid[p] && !found_lo) begin
        found_lo = 1'b1;
        win_lo   = IDX_W'(p);
      end
      if (s_cmd_valid[p] && (IDX_W'(p) >= rr_q) && !found_hi) begin
        found_hi = 1'b1;
        win_hi   = IDX_W'(p);
      end
    end
    req_found = found_hi || found_lo;
    winner    = found_hi ? win_hi : win_lo;
  end

  // Winning command fields and one-hot client ready.
  always_comb begin
    win_cmd     = '0;
    win_cmd.idx = winner;
    s_cmd_ready = '0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (winner == IDX_W'(p)) begin
        win_cmd.sel    = s_cmd_sel[p*S_SEL_W +: S_SEL_W];
        win_cmd.addr   = s_cmd_addr[p*SEG_ADDR_W +: SEG_ADDR_W];
        s_cmd_ready[p] = grant;
      end
    end
  end

  // Output register and round-robin pointer next state.
  always_comb begin
    oreg_d        = oreg_q;
    m_cmd_valid_d = m_cmd_valid_q;
    rr_d          = rr_q;
    if (can_load) begin
      if (grant) begin
        oreg_d        = win_cmd;
        m_cmd_valid_d = 1'b1;
        rr_d          = (winner == IDX_W'(PORTS - 1)) ? '0 : winner + IDX_W'(1);
      end else begin
        m_cmd_valid_d = 1'b0;
      end
    end
  end

  // FIFO pointer and occupancy next state; wrap explicitly at the depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  // Route the RAM response to the port at the FIFO head.
  always_comb begin
    s_resp_valid = '0;
    head_ready   = 1'b0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (head == IDX_W'(p)) begin
        s_resp_valid[p] = m_resp_valid && !fifo_empty;
        head_ready      = s_resp_ready[p];
      end
    end
    m_resp_ready = !fifo_empty && head_ready;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oreg_q        <= '0;
      m_cmd_valid_q <= 1'b0;
      rr_q          <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      oreg_q        <= oreg_d;
      m_cmd_valid_q <= m_cmd_valid_d;
      rr_q          <= rr_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Port-index storage; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= winner;
  end

  assign m_cmd_sel   = {oreg_q.idx, oreg_q.sel};
  assign m_cmd_addr  = oreg_q.addr;
  assign m_cmd_valid = m_cmd_valid_q;

endmodule

// File: rtl/taxi_dma_ram_mux_rd.sv
// Read-side DMA RAM multiplexer: one independent arbiter/router per segment.
// Client buses are port-major: bit (p*SEGS + s) belongs to port p, segment s.
module taxi_dma_ram_mux_rd
  import taxi_dma_ram_mux_pkg::*;
#(
  parameter int unsigned PORTS      = 2,
  parameter int unsigned SEGS       = 2,
  parameter int unsigned SEG_ADDR_W = 12,
  parameter int unsigned SEG_DATA_W = 64,
  parameter int unsigned S_SEL_W    = 1,
  parameter int unsigned FIFO_DEPTH = 16,
  localparam int unsigned M_SEL_W   = calc_m_sel_w(S_SEL_W, PORTS)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [PORTS*SEGS*S_SEL_W-1:0]       s_cmd_sel,
  input  logic [PORTS*SEGS*SEG_ADDR_W-1:0]    s_cmd_addr,
  input  logic [PORTS*SEGS-1:0]               s_cmd_valid,
  output logic [PORTS*SEGS-1:0]               s_cmd_ready,
  output logic [PORTS*SEGS*SEG_DATA_W-1:0]    s_resp_data,
  output logic [PORTS*SEGS-1:0]               s_resp_valid,
  input  logic [PORTS*SEGS-1:0]               s_resp_ready,
  output logic [SEGS*M_SEL_W-1:0]             m_cmd_sel,
  output logic [SEGS*SEG_ADDR_W-1:0]          m_cmd_addr,
  output logic [SEGS-1:0]                     m_cmd_valid,
  input  logic [SEGS-1:0]                     m_cmd_ready,
  input  logic [SEGS*SEG_DATA_W-1:0]          m_resp_data,
  input  logic [SEGS-1:0]                     m_resp_valid,
  output logic [SEGS-1:0]                     m_resp_ready
);

  for (genvar s = 0; s < SEGS; s++) begin : g_seg
    logic [PORTS*S_SEL_W-1:0]    seg_sel;
    logic [PORTS*SEG_ADDR_W-1:0] seg_addr;
    logic [PORTS-1:0]            seg_valid, seg_ready, seg_rvalid, seg_rready;

    for (genvar p = 0; p < PORTS; p++) begin : g_port
      assign seg_sel[p*S_SEL_W +: S_SEL_W]       = s_cmd_sel[(p*SEGS+s)*S_SEL_W +: S_SEL_W];
      assign seg_addr[p*SEG_ADDR_W +: SEG_ADDR_W] = s_cmd_addr[(p*SEGS+s)*SEG_ADDR_W +: SEG_ADDR_W];
      assign seg_valid[p]                         = s_cmd_valid[p*SEGS+s];
      assign seg_rready[p]                        = s_resp_ready[p*SEGS+s];
      assign s_cmd_ready[p*SEGS+s]                = seg_ready[p];
      assign s_resp_valid[p*SEGS+s]               = seg_rvalid[p];
      assign s_resp_data[(p*SEGS+s)*SEG_DATA_W +: SEG_DATA_W] =
        m_resp_data[s*SEG_DATA_W +: SEG_DATA_W];
    end

    taxi_dma_ram_mux_rd_seg #(
      .PORTS      (PORTS),
      .S_SEL_W    (S_SEL_W),
      .SEG_ADDR_W (SEG_ADDR_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_seg (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_cmd_sel    (seg_sel),
      .s_cmd_addr   (seg_addr),
      .s_cmd_valid  (seg_valid),
      .s_cmd_ready  (seg_ready),
      .s_resp_valid (seg_rvalid),
      .s_resp_ready (seg_rready),
      .m_cmd_sel    (m_cmd_sel[s*M_SEL_W +: M_SEL_W]),
      .m_cmd_addr   (m_cmd_addr[s*SEG_ADDR_W +: SEG_ADDR_W]),
      .m_cmd_valid  (m_cmd_valid[s]),
      .m_cmd_ready  (m_cmd_ready[s]),
      .m_resp_valid (m_resp_valid[s]),
      .m_resp_ready (m_resp_ready[s])
    );
  end

endmodule

// File: tb/tb_taxi_dma_ram_mux_rd.sv
// Bench for taxi_dma_ram_mux_rd (PORTS=2, SEGS=2, FIFO_DEPTH=16).
module tb_taxi_dma_ram_mux_rd;

  localparam int P  = 2;
  localparam int S  = 2;
  localparam int AW = 12;
  localparam int DW = 64;
  localparam int D  = 16;

  logic               clk, rst_n;
  logic [P*S-1:0]     s_cmd_sel;
  logic [P*S*AW-1:0]  s_cmd_addr;
  logic [P*S-1:0]     s_cmd_valid, s_cmd_ready;
  logic [P*S*DW-1:0]  s_resp_data;
  logic [P*S-1:0]     s_resp_valid, s_resp_ready;
  logic [S*2-1:0]     m_cmd_sel;
  logic [S*AW-1:0]    m_cmd_addr;
  logic [S-1:0]       m_cmd_valid, m_cmd_ready;
  logic [S*DW-1:0]    m_resp_data;
  logic [S-1:0]       m_resp_valid, m_resp_ready;

  int checks   = 0;
  int failures = 0;

  taxi_dma_ram_mux_rd #(
    .PORTS(P), .SEGS(S), .SEG_ADDR_W(AW), .SEG_DATA_W(DW), .S_SEL_W(1), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_cmd_sel(s_cmd_sel), .s_cmd_addr(s_cmd_addr), .s_cmd_valid(s_cmd_valid),
    .s_cmd_ready(s_cmd_ready), .s_resp_data(s_resp_data), .s_resp_valid(s_resp_valid),
    .s_resp_ready(s_resp_ready), .m_cmd_sel(m_cmd_sel), .m_cmd_addr(m_cmd_addr),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_resp_data(m_resp_data),
    .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int bi(input int p, input int s);
    return p * S + s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    s_cmd_sel    = '0;
    s_cmd_addr   = '0;
    s_cmd_valid  = '0;
    s_resp_ready = '0;
    m_cmd_ready  = '0;
    m_resp_data  = '0;
    m_resp_valid = '0;
  endtask

  // Leaves time at posedge+1 with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scripted single-segment vectors (segment 0, both ports).
  typedef struct {
    logic [1:0]  cv;   logic mr; logic rv; logic [1:0] rdy;
    logic [1:0]  cr;   logic mv; logic [1:0] msel; logic [11:0] maddr;
    logic [1:0]  sv;   logic mrr;
  } vec_t;

  vec_t vecs[11];

  // Reference model state for the randomized phase.
  int          ov[S], o_port[S], rr[S];
  logic        o_sel[S];
  logic [11:0] o_addr[S];
  logic [63:0] o_data[S];
  int          outq[S][$];
  logic [63:0] ramq[S][$];
  logic [63:0] drv_data[S];
  int          delivered;

  initial begin
    int grants;

    // During reset no client sees ready even with requests present.
    rst_n = 1'b0;
    clear_inputs();
    s_cmd_valid = '1;
    #3;
    chk("rst_cmd_ready", 64'(s_cmd_ready), 64'h0);
    chk("rst_m_cmd_valid", 64'(m_cmd_valid), 64'h0);
    do_reset();

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      #3;
      chk("idle_cmd_ready", 64'(s_cmd_ready), 64'h0);
      chk("idle_m_cmd_valid", 64'(m_cmd_valid), 64'h0);
      chk("idle_resp_valid", 64'(s_resp_valid), 64'h0);
      chk("idle_m_resp_ready", 64'(m_resp_ready), 64'h0);
      next_cycle();
    end

    // ---------------- table-driven segment-0 script ----------------
    vecs[0]  = '{2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 2'b00, 12'h000, 2'b00, 1'b0};
    vecs[1]  = '{2'b11, 1'b0, 1'b0, 2'b11, 2'b01, 1'b0, 2'b00, 12'h000, 2'b00, 1'b0};
    vecs[2]  = '{2'b11, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1, 2'b01, 12'h010, 2'b00, 1'b1};
    vecs[3]  = '{2'b11, 1'b1, 1'b1, 2'b11, 2'b10, 1'b1, 2'b01, 12'h010, 2'b01, 1'b1};
    vecs[4]  = '{2'b01, 1'b1, 1'b0, 2'b01, 2'b01, 1'b1, 2'b10, 12'h020, 2'b00, 1'b0};
    vecs[5]  = '{2'b00, 1'b1, 1'b1, 2'b01, 2'b00, 1'b1, 2'b01, 12'h010, 2'b10, 1'b0};
    vecs[6]  = '{2'b00, 1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 2'b00, 12'h000, 2'b10, 1'b1};
    vecs[7]  = '{2'b10, 1'b0, 1'b1, 2'b11, 2'b10, 1'b0, 2'b00, 12'h000, 2'b01, 1'b1};
    vecs[8]  = '{2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 12'h020, 2'b00, 1'b0};
    vecs[9]  = '{2'b00, 1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 2'b00, 12'h000, 2'b10, 1'b1};
    vecs[10] = '{2'b00, 1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 2'b00, 12'h000, 2'b00, 1'b0};

    do_reset();
    s_cmd_sel[bi(0,0)] = 1'b1;
    s_cmd_sel[bi(1,0)] = 1'b0;
    s_cmd_addr[bi(0,0)*AW +: AW] = 12'h010;
    s_cmd_addr[bi(1,0)*AW +: AW] = 12'h020;
    for (int i = 0; i < 11; i++) begin
      s_cmd_valid[bi(0,0)]  = vecs[i].cv[0];
      s_cmd_valid[bi(1,0)]  = vecs[i].cv[1];
      s_resp_ready[bi(0,0)] = vecs[i].rdy[0];
      s_resp_ready[bi(1,0)] = vecs[i].rdy[1];
      m_cmd_ready[0]  = vecs[i].mr;
      m_resp_valid[0] = vecs[i].rv;
      m_resp_data[0 +: DW] = 64'hDEAD_BEEF + 64'(i);
      #3;
      chk($sformatf("vec%0d_cmd_ready", i),
          64'({s_cmd_ready[bi(1,0)], s_cmd_ready[bi(0,0)]}), 64'(vecs[i].cr));
      chk($sformatf("vec%0d_m_cmd_valid", i), 64'(m_cmd_valid[0]), 64'(vecs[i].mv));
      if (vecs[i].mv) begin
        chk($sformatf("vec%0d_m_cmd_sel", i), 64'(m_cmd_sel[1:0]), 64'(vecs[i].msel));
        chk($sformatf("vec%0d_m_cmd_addr", i), 64'(m_cmd_addr[AW-1:0]), 64'(vecs[i].maddr));
      end
      chk($sformatf("vec%0d_resp_valid", i),
          64'({s_resp_valid[bi(1,0)], s_resp_valid[bi(0,0)]}), 64'(vecs[i].sv));
      chk($sformatf("vec%0d_m_resp_ready", i), 64'(m_resp_ready[0]), 64'(vecs[i].mrr));
      if (vecs[i].sv != 2'b00)
        for (int p = 0; p < P; p++)
          chk($sformatf("vec%0d_resp_data_p%0d", i, p),
              s_resp_data[bi(p,0)*DW +: DW], 64'hDEAD_BEEF + 64'(i));
      next_cycle();
    end

    // ---------------- alternating grants on segment 1 ----------------
    do_reset();
    s_cmd_valid[bi(0,1)] = 1'b1;
    s_cmd_valid[bi(1,1)] = 1'b1;
    m_cmd_ready[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #3;
      chk($sformatf("alt%0d_ready", i),
          64'({s_cmd_ready[bi(1,1)], s_cmd_ready[bi(0,1)]}), (i % 2 == 0) ? 64'h1 : 64'h2);
      if (i > 0)
        chk($sformatf("alt%0d_idx", i), 64'(m_cmd_sel[3]), (i % 2 == 1) ? 64'h0 : 64'h1);
      next_cycle();
    end

    // ---------------- FIFO full boundary ----------------
    do_reset();
    s_cmd_valid[bi(0,0)] = 1'b1;
    m_cmd_ready[0] = 1'b1;
    s_resp_ready = '1;
    grants = 0;
    for (int i = 0; i < 30; i++) begin
      #3;
      if (s_cmd_ready[bi(0,0)]) grants++;
      next_cycle();
    end
    chk("full_grants", 64'(grants), 64'd16);
    m_resp_valid[0] = 1'b1;
    #3;
    chk("full_pop_cycle_ready", 64'(s_cmd_ready[bi(0,0)]), 64'h0);
    chk("full_pop_m_resp_ready", 64'(m_resp_ready[0]), 64'h1);
    next_cycle();
    m_resp_valid[0] = 1'b0;
    grants = 0;
    for (int i = 0; i < 5; i++) begin
      #3;
      if (s_cmd_ready[bi(0,0)]) grants++;
      next_cycle();
    end
    chk("full_regrant", 64'(grants), 64'd1);

    // ---------------- reset with reads outstanding ----------------
    do_reset();
    s_cmd_valid[bi(0,0)] = 1'b1;
    m_cmd_ready[0] = 1'b1;
    repeat (4) next_cycle();
    s_cmd_valid = '0;
    m_cmd_ready = '0;
    #3;
    chk("rstmid_valid_before", 64'(m_cmd_valid[0]), 64'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_valid_async", 64'(m_cmd_valid[0]), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_resp_valid = '1;
    s_resp_ready = '1;
    m_resp_data  = {2{64'h0BAD_0BAD_0BAD_0BAD}};
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("rstmid_m_resp_ready", 64'(m_resp_ready), 64'h0);
      chk("rstmid_resp_valid", 64'(s_resp_valid), 64'h0);
      next_cycle();
    end

    // ---------------- randomized traffic vs reference model ----------------
    do_reset();
    for (int s = 0; s < S; s++) begin
      ov[s] = 0; rr[s] = 0; o_port[s] = 0; o_sel[s] = 1'b0; o_addr[s] = '0; o_data[s] = '0;
      outq[s].delete();
      ramq[s].delete();
    end
    delivered = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bit stall_resp;
      stall_resp = (cyc >= 500 && cyc < 600);
      s_cmd_valid = 4'($urandom);
      s_cmd_sel   = 4'($urandom);
      s_cmd_addr  = {$urandom, $urandom};
      for (int s = 0; s < S; s++) begin
        m_cmd_ready[s] = ($urandom_range(0, 3) != 0);
        if (ramq[s].size() > 0 && !stall_resp && $urandom_range(0, 2) != 0) begin
          m_resp_valid[s] = 1'b1;
          drv_data[s] = ramq[s][0];
        end else begin
          m_resp_valid[s] = 1'b0;
          drv_data[s] = {$urandom, $urandom};
        end
        m_resp_data[s*DW +: DW] = drv_data[s];
      end
      for (int b = 0; b < P*S; b++)
        s_resp_ready[b] = (cyc >= 900 && cyc < 1000) ? ($urandom_range(0, 3) == 0)
                                                     : ($urandom_range(0, 4) != 0);
      #3;
      for (int s = 0; s < S; s++) begin
        bit can_load, found, grant, exp_mrr, empty;
        int w, head;
        can_load = (ov[s] == 0) || m_cmd_ready[s];
        found = 0;
        w = 0;
        for (int k = 0; k < P; k++) begin
          int pp;
          pp = (rr[s] + k) % P;
          if (!found && s_cmd_valid[bi(pp,s)]) begin
            found = 1;
            w = pp;
          end
        end
        grant = can_load && (outq[s].size() < D) && found;
        for (int p = 0; p < P; p++)
          chk($sformatf("rnd_c%0d_s%0d_cmd_ready_p%0d", cyc, s, p),
              64'(s_cmd_ready[bi(p,s)]), 64'(grant && (w == p)));
        chk($sformatf("rnd_c%0d_s%0d_m_cmd_valid", cyc, s), 64'(m_cmd_valid[s]), 64'(ov[s] != 0));
        if (ov[s] != 0) begin
          chk($sformatf("rnd_c%0d_s%0d_m_cmd_sel", cyc, s),
              64'(m_cmd_sel[s*2 +: 2]), 64'({1'(o_port[s]), o_sel[s]}));
          chk($sformatf("rnd_c%0d_s%0d_m_cmd_addr", cyc, s),
              64'(m_cmd_addr[s*AW +: AW]), 64'(o_addr[s]));
        end
        empty = (outq[s].size() == 0);
        head  = empty ? 0 : outq[s][0];
        exp_mrr = !empty && s_resp_ready[bi(head,s)];
        chk($sformatf("rnd_c%0d_s%0d_m_resp_ready", cyc, s), 64'(m_resp_ready[s]), 64'(exp_mrr));
        for (int p = 0; p < P; p++) begin
          bit ev;
          ev = m_resp_valid[s] && !empty && (head == p);
          chk($sformatf("rnd_c%0d_s%0d_resp_valid_p%0d", cyc, s, p),
              64'(s_resp_valid[bi(p,s)]), 64'(ev));
          if (ev)
            chk($sformatf("rnd_c%0d_s%0d_resp_data_p%0d", cyc, s, p),
                s_resp_data[bi(p,s)*DW +: DW], drv_data[s]);
        end
        // Model state advance at the coming edge.
        if (ov[s] != 0 && m_cmd_ready[s]) ramq[s].push_back(o_data[s]);
        if (m_resp_valid[s] && exp_mrr) begin
          void'(outq[s].pop_front());
          void'(ramq[s].pop_front());
          delivered++;
        end
        if (can_load) begin
          if (grant) begin
            ov[s]     = 1;
            o_port[s] = w;
            o_sel[s]  = s_cmd_sel[bi(w,s)];
            o_addr[s] = s_cmd_addr[bi(w,s)*AW +: AW];
            o_data[s] = {$urandom, $urandom};
            rr[s]     = (w + 1) % P;
            outq[s].push_back(w);
          end else begin
            ov[s] = 0;
          end
        end
      end
      next_cycle();
    end
    checks++;
    if (delivered < 200) begin
      failures++;
      $display("FAIL rnd_delivered actual=%0d required=>=200", delivered);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
